rtc_regfile_wb: RTL and testbench

- Parametrised register file holding the RTC time/date/timer image. Sits between the RTC bus controller (hardware side) and the user-edit/display logic (software side).
- Two write ports with defined priority, one registered read port, and a read-only derived "timer active" flag register.
- Dirty-bit tracking plus a round-robin write-back engine that pushes user-edited registers back to the RTC over a valid/ready handshake.

---
 rtl/rtc_regfile_pkg.sv | 20 ++
 rtl/rtc_regfile_wb_if.sv | 13 +
 rtl/rtc_wb_scanner.sv | 107 ++++++++++
 rtl/rtc_regfile_wb.sv | 136 +++++++++++++
 tb/tb_rtc_regfile_wb.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_regfile_pkg.sv
// Shared types and default register map for the RTC register file.
package rtc_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    OFFER = 2'd2
  } wb_state_e;

  localparam int unsigned ADDR_SEC    = 0;
  localparam int unsigned ADDR_MIN    = 1;
  localparam int unsigned ADDR_HOUR   = 2;
  localparam int unsigned ADDR_DAY    = 3;
  localparam int unsigned ADDR_MONTH  = 4;
  localparam int unsigned ADDR_YEAR   = 5;
  localparam int unsigned ADDR_TMR_LO = 7;
  localparam int unsigned ADDR_TMR_N  = 3;
  localparam int unsigned ADDR_FLAG   = 11;

endpackage

// File: rtl/rtc_regfile_wb_if.sv
// Write-back handshake from the register file (master) to the RTC controller (slave).
interface rtc_regfile_wb_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) ();
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  modport master (output wb_valid, output wb_addr, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_addr, input wb_data, output wb_ready);
endinterface

// File: rtl/rtc_wb_scanner.sv
// Round-robin dirty search and write-back offer FSM.
// latch_c is only exported when PARITY_EN is defined.
module rtc_wb_scanner
  import rtc_regfile_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] dirty,
  input  logic             sw_ok,
  input  logic [AW-1:0]    sw_addr,
  output logic [AW-1:0]    look_addr,
  input  logic [DW-1:0]    look_data,
`ifdef PARITY_EN
  output logic             latch_c,
`endif
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [AW-1:0]    wb_addr,
  output logic [DW-1:0]    wb_data,
  output logic             clr_c,
  output logic [AW-1:0]    clr_idx_c
);

  wb_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          stale_q, stale_d;
  logic          hit_c;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // stale marks an offer whose register was rewritten after the data was latched
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    stale_d = stale_q;
    hit_c   = 1'b0;
    clr_c   = 1'b0;
    unique case (state_q)
      IDLE: if (|dirty) state_d = SCAN;
      SCAN: begin
        if (dirty[ptr_q]) begin
          hit_c   = 1'b1;
          addr_d  = ptr_q;
          data_d  = look_data;
          valid_d = 1'b1;
          stale_d = sw_ok && (sw_addr == ptr_q);
          state_d = OFFER;
        end else if (!(|dirty)) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_inc(ptr_q);
        end
      end
      OFFER: begin
        if (sw_ok && (sw_addr == addr_q)) stale_d = 1'b1;
        if (wb_ready) begin
          clr_c   = !(stale_q || (sw_ok && (sw_addr == addr_q)));
          valid_d = 1'b0;
          stale_d = 1'b0;
          ptr_d   = ptr_inc(addr_q);
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      stale_q <= stale_d;
    end
  end

  assign look_addr = ptr_q;
  assign clr_idx_c = addr_q;
  assign wb_valid  = valid_q;
  assign wb_addr   = addr_q;
  assign wb_data   = data_q;
`ifdef PARITY_EN
  assign latch_c   = hit_c;
`endif

endmodule

// File: rtl/rtc_regfile_wb.sv
// RTC time/date/timer register file with dirty tracking and round-robin write-back.
// Optional PARITY_EN adds per-register even parity and a registered parity_err output.
module rtc_regfile_wb
  import rtc_regfile_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TMR_LO    = ADDR_TMR_LO,
  parameter int unsigned TMR_N     = ADDR_TMR_N,
  parameter int unsigned FLAG_ADDR = ADDR_FLAG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hw_we,
  input  logic [AW-1:0]   hw_addr,
  input  logic [DW-1:0]   hw_wdata,
  input  logic            sw_we,
  input  logic [AW-1:0]   sw_addr,
  input  logic [DW-1:0]   sw_wdata,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  rtc_regfile_wb_if.master wb,
  output logic            timer_active,
  output logic            dirty_any
`ifdef PARITY_EN
  ,
  output logic            parity_err
`endif
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             dirty_any_q;
  logic             sw_ok_c, hw_ok_c, tmr_any_c;
  logic [DW-1:0]    flag_val_c;
  logic [AW-1:0]    look_addr_c;
  logic [DW-1:0]    look_data_c;
  logic             clr_c;
  logic [AW-1:0]    clr_idx_c;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && (32'(a) != FLAG_ADDR);
  endfunction

  // hw readback never overwrites a pending user edit, and loses same-address collisions
  assign sw_ok_c = sw_we && addr_ok(sw_addr);
  assign hw_ok_c = hw_we && addr_ok(hw_addr) && !dirty_q[hw_addr]
                   && !(sw_ok_c && (sw_addr == hw_addr));
  assign look_data_c = mem_q[look_addr_c];

  always_comb begin
    tmr_any_c = 1'b0;
    for (int unsigned i = 0; i < TMR_N; i++) tmr_any_c = tmr_any_c || (mem_q[TMR_LO + i] != '0);
  end
  assign flag_val_c = tmr_any_c ? '1 : '0;

  always_comb begin
    mem_d   = mem_q;
    dirty_d = dirty_q;
    if (hw_ok_c) mem_d[hw_addr] = hw_wdata;
    if (sw_ok_c) mem_d[sw_addr] = sw_wdata;
    mem_d[FLAG_ADDR] = flag_val_c;
    if (clr_c) dirty_d[clr_idx_c] = 1'b0;
    if (sw_ok_c) dirty_d[sw_addr] = 1'b1;
    rd_data_d = (32'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q       <= '{default: '0};
      dirty_q     <= '0;
      rd_data_q   <= '0;
      dirty_any_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      dirty_q     <= dirty_d;
      rd_data_q   <= rd_data_d;
      dirty_any_q <= |dirty_d;
    end
  end

`ifdef PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
  logic             perr_q, perr_d;
  logic             latch_c;

  // even parity: stored bit equals XOR of the data bits
  always_comb begin
    par_d = par_q;
    if (hw_ok_c) par_d[hw_addr] = ^hw_wdata;
    if (sw_ok_c) par_d[sw_addr] = ^sw_wdata;
    par_d[FLAG_ADDR] = ^flag_val_c;
    perr_d = ((32'(rd_addr) < DEPTH) && ((^mem_q[rd_addr]) != par_q[rd_addr]))
             || (latch_c && ((^look_data_c) != par_q[look_addr_c]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`endif

  rtc_wb_scanner #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_scan (
    .clk       (clk),
    .reset     (reset),
    .dirty     (dirty_q),
    .sw_ok     (sw_ok_c),
    .sw_addr   (sw_addr),
    .look_addr (look_addr_c),
    .look_data (look_data_c),
`ifdef PARITY_EN
    .latch_c   (latch_c),
`endif
    .wb_valid  (wb.wb_valid),
    .wb_ready  (wb.wb_ready),
    .wb_addr   (wb.wb_addr),
    .wb_data   (wb.wb_data),
    .clr_c     (clr_c),
    .clr_idx_c (clr_idx_c)
  );

  assign rd_data      = rd_data_q;
  assign timer_active = mem_q[FLAG_ADDR][0];
  assign dirty_any    = dirty_any_q;

endmodule

// File: tb/tb_rtc_regfile_wb.sv
// Directed self-checking bench for rtc_regfile_wb.
module tb_rtc_regfile_wb;

  logic       clk = 1'b0;
  logic       reset;
  logic       hw_we, sw_we;
  logic [3:0] hw_addr, sw_addr, rd_addr;
  logic [7:0] hw_wdata, sw_wdata;
  logic [7:0] rd_data;
  logic       timer_active, dirty_any;
`ifdef PARITY_EN
  logic       parity_err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  rtc_regfile_wb_if #(.AW(4), .DW(8)) wb_bus ();

  rtc_regfile_wb dut (
    .clk          (clk),
    .reset        (reset),
    .hw_we        (hw_we),
    .hw_addr      (hw_addr),
    .hw_wdata     (hw_wdata),
    .sw_we        (sw_we),
    .sw_addr      (sw_addr),
    .sw_wdata     (sw_wdata),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wb           (wb_bus),
    .timer_active (timer_active),
    .dirty_any    (dirty_any)
`ifdef PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hw_we = 1'b0; hw_addr = '0; hw_wdata = '0;
    sw_we = 1'b0; sw_addr = '0; sw_wdata = '0;
    rd_addr = '0;
    wb_bus.wb_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic sw_write(input logic [3:0] a, input logic [7:0] d);
    sw_we = 1'b1; sw_addr = a; sw_wdata = d;
    step();
    sw_we = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (wb_bus.wb_valid !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    vectors++;
    if (wb_bus.wb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: wb_valid timeout, got %b want 1", name, wb_bus.wb_valid);
    end
  endtask

  task automatic wait_clean(input string name);
    int n = 0;
    while (dirty_any !== 1'b0 && n < 128) begin
      step();
      n++;
    end
    vectors++;
    if (dirty_any !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: dirty_any never cleared, got %b want 0", name, dirty_any);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (wb_bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid: got %b want 0", wb_bus.wb_valid); end
    vectors++;
    if (dirty_any !== 1'b0 || timer_active !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: dirty_any %b timer_active %b want 0 0", dirty_any, timer_active);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      step();
      vectors++;
      if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_read[%0d]: got %h want 00", a, rd_data); end
    end
  endtask

  task automatic test_priority();
    sw_write(4'd1, 8'h30);
    hw_we = 1'b1; hw_addr = 4'd1; hw_wdata = 8'h45;
    step();
    hw_we = 1'b0;
    rd_addr = 4'd1;
    step();
    vectors++;
    if (rd_data !== 8'h30) begin miscompares++; $display("FAIL hw_blocked_by_dirty: got %h want 30", rd_data); end
    wait_valid("prio_offer");
    vectors++;
    if (wb_bus.wb_addr !== 4'd1 || wb_bus.wb_data !== 8'h30) begin
      miscompares++; $display("FAIL prio_offer_payload: got %h/%h want 1/30", wb_bus.wb_addr, wb_bus.wb_data);
    end
    wb_bus.wb_ready = 1'b1;
    step();
    wb_bus.wb_ready = 1'b0;
    vectors++;
    if (wb_bus.wb_valid !== 1'b0 || dirty_any !== 1'b0) begin
      miscompares++; $display("FAIL prio_handshake: wb_valid %b dirty_any %b want 0 0", wb_bus.wb_valid, dirty_any);
    end
    hw_we = 1'b1; hw_addr = 4'd1; hw_wdata = 8'h45;
    step();
    hw_we = 1'b0;
    step();
    vectors++;
    if (rd_data !== 8'h45 || dirty_any !== 1'b0) begin
      miscompares++; $display("FAIL hw_write_clean: rd %h dirty_any %b want 45 0", rd_data, dirty_any);
    end
  endtask

  task automatic test_timer_flag();
    wb_bus.wb_ready = 1'b1;
    rd_addr = 4'd11;
    sw_write(4'd8, 8'h05);
    vectors++;
    if (timer_active !== 1'b0) begin miscompares++; $display("FAIL flag_lag: got %b want 0", timer_active); end
    step();
    vectors++;
    if (timer_active !== 1'b1 || rd_data !== 8'h00) begin
      miscompares++; $display("FAIL flag_set: active %b rd %h want 1 00", timer_active, rd_data);
    end
    step();
    vectors++;
    if (rd_data !== 8'hFF) begin miscompares++; $display("FAIL flag_read: got %h want FF", rd_data); end
    wait_clean("timer_drain1");
    sw_write(4'd8, 8'h00);
    step();
    step();
    vectors++;
    if (timer_active !== 1'b0 || rd_data !== 8'h00) begin
      miscompares++; $display("FAIL flag_clear: active %b rd %h want 0 00", timer_active, rd_data);
    end
    wait_clean("timer_drain2");
    sw_we = 1'b1; sw_addr = 4'd11; sw_wdata = 8'h12;
    hw_we = 1'b1; hw_addr = 4'd11; hw_wdata = 8'h12;
    step();
    sw_we = 1'b0; hw_we = 1'b0;
    vectors++;
    if (dirty_any !== 1'b0) begin miscompares++; $display("FAIL flag_write_dirty: got %b want 0", dirty_any); end
    step();
    step();
    vectors++;
    if (rd_data !== 8'h00) begin miscompares++; $display("FAIL flag_write_ignored: got %h want 00", rd_data); end
    wb_bus.wb_ready = 1'b0;
  endtask

  task automatic test_hold_order();
    do_reset();
    sw_write(4'd3, 8'h33);
    sw_write(4'd14, 8'hE4);
    wait_valid("order_first");
    vectors++;
    if (wb_bus.wb_addr !== 4'd3 || wb_bus.wb_data !== 8'h33) begin
      miscompares++; $display("FAIL order_first: got %h/%h want 3/33", wb_bus.wb_addr, wb_bus.wb_data);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (wb_bus.wb_valid !== 1'b1 || wb_bus.wb_addr !== 4'd3 || wb_bus.wb_data !== 8'h33) begin
        miscompares++;
        $display("FAIL hold[%0d]: got %b %h/%h want 1 3/33", i, wb_bus.wb_valid, wb_bus.wb_addr, wb_bus.wb_data);
      end
    end
    wb_bus.wb_ready = 1'b1;
    step();
    wb_bus.wb_ready = 1'b0;
    wait_valid("order_second");
    vectors++;
    if (wb_bus.wb_addr !== 4'd14 || wb_bus.wb_data !== 8'hE4) begin
      miscompares++; $display("FAIL order_second: got %h/%h want E/E4", wb_bus.wb_addr, wb_bus.wb_data);
    end
    wb_bus.wb_ready = 1'b1;
    wait_clean("order_drain");
    wb_bus.wb_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    sw_write(4'd3, 8'h11);
    wait_valid("resend_first");
    wb_bus.wb_ready = 1'b1;
    sw_we = 1'b1; sw_addr = 4'd3; sw_wdata = 8'h22;
    vectors++;
    if (wb_bus.wb_addr !== 4'd3 || wb_bus.wb_data !== 8'h11) begin
      miscompares++; $display("FAIL resend_first: got %h/%h want 3/11", wb_bus.wb_addr, wb_bus.wb_data);
    end
    step();
    sw_we = 1'b0;
    wb_bus.wb_ready = 1'b0;
    vectors++;
    if (wb_bus.wb_valid !== 1'b0 || dirty_any !== 1'b1) begin
      miscompares++; $display("FAIL resend_keep_dirty: wb_valid %b dirty_any %b want 0 1", wb_bus.wb_valid, dirty_any);
    end
    wait_valid("resend_second");
    vectors++;
    if (wb_bus.wb_addr !== 4'd3 || wb_bus.wb_data !== 8'h22) begin
      miscompares++; $display("FAIL resend_second: got %h/%h want 3/22", wb_bus.wb_addr, wb_bus.wb_data);
    end
    wb_bus.wb_ready = 1'b1;
    step();
    wb_bus.wb_ready = 1'b0;
    vectors++;
    if (dirty_any !== 1'b0) begin miscompares++; $display("FAIL resend_clear: got %b want 0", dirty_any); end
  endtask

  task automatic test_reset_offer();
    sw_write(4'd5, 8'h77);
    wait_valid("rst_offer");
    reset = 1'b1;
    step();
    vectors++;
    if (wb_bus.wb_valid !== 1'b0 || dirty_any !== 1'b0) begin
      miscompares++; $display("FAIL rst_offer_drop: wb_valid %b dirty_any %b want 0 0", wb_bus.wb_valid, dirty_any);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rd_addr = 4'd5;
    step();
    vectors++;
    if (wb_bus.wb_valid !== 1'b0 || rd_data !== 8'h00) begin
      miscompares++; $display("FAIL rst_offer_after: wb_valid %b rd %h want 0 00", wb_bus.wb_valid, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_timer_flag();
    test_hold_order();
    test_back_to_back();
    test_reset_offer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
